bp_io_cmd_arbiter: RTL and testbench
====================================

Name: bp_io_cmd_arbiter

Overview:
- Shares one BedRock IO command/response channel into the core between `num_req_p` requesters, e.g. the NBF loader (req 0) and the Ethernet host bridge (req 1).
- Arbitrates commands round-robin at message granularity.
- Records the source of every granted command in an in-order tag FIFO and steers each returning response to that source.
- Sits in the tethered top between the host-side IO sources and the wrapper's single `io_cmd` / `io_resp` port.

Parameters:
- `num_req_p`, 2, number of requesters; at least 2.
- `io_msg_width_p`, 128, width of a packed BedRock IO message (`cce_mem_msg_width_lp` at instantiation).
- `max_outstanding_p`, 8, tag FIFO depth: maximum commands in flight without a response.
- `lg_num_req_lp`, `$clog2(num_req_p)`, tag width (derived; not overridable).

Ports:
- `clk_i`  input  1  sole clock.
- `reset_i`  input  1  synchronous, active-high reset.
- `req_cmd_i`  input  `num_req_p` x `io_msg_width_p`  per-requester command message.
- `req_cmd_v_i`  input  `num_req_p`  per-requester command valid.
- `req_cmd_yumi_o`  output  `num_req_p`  per-requester command consumed.
- `req_resp_o`  output  `num_req_p` x `io_msg_width_p`  response message, same data broadcast to all requesters.
- `req_resp_v_o`  output  `num_req_p`  per-requester response valid.
- `req_resp_ready_and_i`  input  `num_req_p`  per-requester response ready.
- `io_cmd_o`  output  `io_msg_width_p`  arbitrated command to the core.
- `io_cmd_v_o`  output  1  command valid.
- `io_cmd_ready_and_i`  input  1  core ready for a command.
- `io_resp_i`  input  `io_msg_width_p`  response from the core.
- `io_resp_v_i`  input  1  response valid.
- `io_resp_yumi_o`  output  1  response consumed.
- `outstanding_o`  output  `$clog2(max_outstanding_p+1)`  commands in flight.
- `orphan_resp_o`  output  1  sticky error: a response arrived with no outstanding command.

Behaviour:
- **Reset:**
  - rr pointer = 0; tag FIFO empty; `outstanding_o` = 0; `orphan_resp_o` = 0.
  - While `reset_i` is high, `io_cmd_v_o`, `req_cmd_yumi_o`, `req_resp_v_o` and `io_resp_yumi_o` are all forced to 0.
- **Command path (combinational, zero-latency):**
  - The winner is the first requester with `req_cmd_v_i` set, searching upward from the rr pointer with wrap-around.
  - `io_cmd_o` = winner's `req_cmd_i`.
  - `io_cmd_v_o` = any `req_cmd_v_i` AND tag FIFO not full.
  - `req_cmd_yumi_o[w]` = `io_cmd_v_o` & `io_cmd_ready_and_i` & (w == winner).
  - Grant never depends on the yumi outputs; the valid output does not depend on `io_cmd_ready_and_i`.
- **On a grant:**
  - Push the winner's index into the tag FIFO.
  - rr pointer <= (winner+1) mod `num_req_p`.
  - The pointer is unchanged on cycles with no grant.
- **Full condition:**
  - Count == `max_outstanding_p` blocks all grants.
  - A pop in the same cycle does NOT unblock a push; full is evaluated from the registered count.
- **Response path:**
  - With the FIFO non-empty and head tag h: `req_resp_o` = `io_resp_i`; `req_resp_v_o[h]` = `io_resp_v_i`; all other bits 0.
  - `io_resp_yumi_o` = `io_resp_v_i` & `req_resp_ready_and_i[h]`; the FIFO pops on yumi.
- **Orphan response:** `io_resp_v_i` with the FIFO empty:
  - `io_resp_yumi_o` = 1 and the response is dropped.
  - `orphan_resp_o` sets and stays set until reset.
  - A simulation `$error` fires.
- **Counter:**
  - Simultaneous push and pop leaves `outstanding_o` unchanged.
  - `outstanding_o` equals the FIFO occupancy at all times.
- **Ordering:** responses are assumed in command order; the core IO path is in-order. Reordering is out of scope.
- **Reset mid-operation:**
  - All in-flight tags are discarded.
  - Responses arriving after reset are treated as orphans.
- **Assertions:** no X on `io_cmd_v_o`; a pop never happens on an empty FIFO unless it is the orphan path.

Optional Feature:
- `BP_IO_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority; the lowest index wins (NBF loader first) and the rr pointer register is removed.
  - Undefined: round-robin as above.
- Tag FIFO, routing and orphan handling are identical in both builds.

Test Plan:
- **Single requester:** req0 sends 3 cmds with `io_cmd_ready_and_i` = 1 -> 3 yumis on consecutive cycles; `outstanding_o` = 3; 3 responses go to `req_resp_v_o[0]` only; `outstanding_o` returns to 0.
- **Fairness:** req0 and req1 both continuously valid, ready = 1, 8 cycles -> grants alternate 0,1,0,1… (4 each); with `BP_IO_ARB_FIXED_PRIO_EN` -> all 8 grants go to req0.
- **Full:** `max_outstanding_p` = 8 and responses withheld -> exactly 8 grants, then `io_cmd_v_o` = 0 while requests stay valid. One response pops -> no grant that cycle; a grant follows the next cycle.
- **Response routing and backpressure:** grant order 1,0,1; hold `req_resp_ready_and_i[1]` = 0 for 5 cycles -> `io_resp_yumi_o` = 0 for those 5 cycles and req0 sees no valid; the responses then deliver to 1,0,1 in order.
- **Orphan:** after reset, drive `io_resp_v_i` = 1 for one cycle -> `io_resp_yumi_o` = 1, no `req_resp_v_o`, `orphan_resp_o` = 1 and stays 1 until `reset_i`.
- **Reset mid-flight:** assert `reset_i` with 4 outstanding -> all outputs 0 the next cycle, `outstanding_o` = 0, rr pointer = 0.

Source files
------------

// File: rtl/bp_io_cmd_arbiter.sv
// bp_io_cmd_arbiter: shares one BedRock IO command/response channel between num_req_p
// requesters. Commands are arbitrated per message. The source of each granted command is
// pushed into an in-order tag FIFO, and each response is steered back to the source at the
// FIFO head.
//
// Optional build macro BP_IO_ARB_FIXED_PRIO_EN:
//   defined   - fixed priority; the lowest index wins and no rr pointer register exists.
//   undefined - round-robin, searching upward from the rr pointer.
//
// orphan_error_en_p gates only the simulation $error for orphan responses. The sticky
// orphan_resp_o flag is always produced.

module bp_io_cmd_arbiter #(
   parameter int unsigned num_req_p         = 2,
   parameter int unsigned io_msg_width_p    = 128,
   parameter int unsigned max_outstanding_p = 8,
   parameter bit          orphan_error_en_p = 1'b1,
   localparam int unsigned lg_num_req_lp    = $clog2(num_req_p),
   localparam int unsigned cnt_width_lp     = $clog2(max_outstanding_p + 1)
) (
   input  logic                                clk_i,
   input  logic                                reset_i,

   input  logic [num_req_p*io_msg_width_p-1:0] req_cmd_i,
   input  logic [num_req_p-1:0]                req_cmd_v_i,
   output logic [num_req_p-1:0]                req_cmd_yumi_o,

   output logic [num_req_p*io_msg_width_p-1:0] req_resp_o,
   output logic [num_req_p-1:0]                req_resp_v_o,
   input  logic [num_req_p-1:0]                req_resp_ready_and_i,

   output logic [io_msg_width_p-1:0]           io_cmd_o,
   output logic                                io_cmd_v_o,
   input  logic                                io_cmd_ready_and_i,

   input  logic [io_msg_width_p-1:0]           io_resp_i,
   input  logic                                io_resp_v_i,
   output logic                                io_resp_yumi_o,

   output logic [cnt_width_lp-1:0]             outstanding_o,
   output logic                                orphan_resp_o
);

   localparam int unsigned ptr_width_lp =
      (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;

   logic [lg_num_req_lp-1:0] winner;
   logic                     found;
   logic                     fifo_full, fifo_empty;
   logic                     push, pop, orphan_hit;
   logic [lg_num_req_lp-1:0] head_tag;

   logic [cnt_width_lp-1:0]  count_q, count_d;
   logic [ptr_width_lp-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic                     orphan_q, orphan_d;
   logic [lg_num_req_lp-1:0] tag_mem_q [max_outstanding_p];

   function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] ptr);
      return (ptr == ptr_width_lp'(max_outstanding_p - 1)) ? '0 : ptr + 1'b1;
   endfunction

   // Full is taken from the registered count, so a same-cycle pop never frees a push slot.
   assign fifo_full  = (count_q == cnt_width_lp'(max_outstanding_p));
   assign fifo_empty = (count_q == '0);
   assign head_tag   = tag_mem_q[rd_ptr_q];

`ifdef BP_IO_ARB_FIXED_PRIO_EN
   // Winner select: the lowest valid index wins.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      for (int unsigned i = 0; i < num_req_p; i++) begin
         if (!found && req_cmd_v_i[i]) begin
            found  = 1'b1;
            winner = lg_num_req_lp'(i);
         end
      end
   end
`else
   logic [lg_num_req_lp-1:0] rr_q, rr_d;

   // Winner select: search at or above rr_q first, then wrap to the indices below it.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      for (int unsigned i = 0; i < num_req_p; i++) begin
         if (!found && req_cmd_v_i[i] && (lg_num_req_lp'(i) >= rr_q)) begin
            found  = 1'b1;
            winner = lg_num_req_lp'(i);
         end
      end
      for (int unsigned i = 0; i < num_req_p; i++) begin
         if (!found && req_cmd_v_i[i]) begin
            found  = 1'b1;
            winner = lg_num_req_lp'(i);
         end
      end
   end

   // Next rr pointer: advance past the winner only on a grant.
   always_comb begin
      rr_d = rr_q;
      if (push) begin
         rr_d = (winner == lg_num_req_lp'(num_req_p - 1)) ? '0 : winner + 1'b1;
      end
   end

   // rr pointer register.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rr_q <= '0;
      end else begin
         rr_q <= rr_d;
      end
   end
`endif

   // Command path: mux the winner's message and decode the grant into a yumi.
   always_comb begin
      io_cmd_o       = req_cmd_i[io_msg_width_p-1:0];
      io_cmd_v_o     = !reset_i && (|req_cmd_v_i) && !fifo_full;
      push           = io_cmd_v_o && io_cmd_ready_and_i;
      req_cmd_yumi_o = '0;
      for (int unsigned i = 0; i < num_req_p; i++) begin
         if (winner == lg_num_req_lp'(i)) begin
            io_cmd_o          = req_cmd_i[i*io_msg_width_p +: io_msg_width_p];
            req_cmd_yumi_o[i] = push;
         end
      end
   end

   // Response path: steer to the head tag; with no tag in flight, sink the response.
   always_comb begin
      req_resp_o     = {num_req_p{io_resp_i}};
      req_resp_v_o   = '0;
      io_resp_yumi_o = 1'b0;
      if (!reset_i) begin
         if (fifo_empty) begin
            io_resp_yumi_o = io_resp_v_i;
         end else begin
            for (int unsigned i = 0; i < num_req_p; i++) begin
               if (head_tag == lg_num_req_lp'(i)) begin
                  req_resp_v_o[i] = io_resp_v_i;
                  io_resp_yumi_o  = io_resp_v_i && req_resp_ready_and_i[i];
               end
            end
         end
      end
      pop        = io_resp_yumi_o && !fifo_empty;
      orphan_hit = !reset_i && io_resp_v_i && fifo_empty;
   end

   // Next-state for FIFO pointers, occupancy count and the sticky orphan flag.
   always_comb begin
      wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
      orphan_d = orphan_q || orphan_hit;
   end

   // FIFO control and status registers; reset discards every in-flight tag.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         orphan_q <= 1'b0;
      end else begin
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         orphan_q <= orphan_d;
      end
   end

   // Tag storage: no reset needed, entries are only read below the occupancy count.
   always_ff @(posedge clk_i) begin
      if (push) begin
         tag_mem_q[wr_ptr_q] <= winner;
      end
   end

   assign outstanding_o = count_q;
   assign orphan_resp_o = orphan_q;

`ifndef SYNTHESIS
   // Simulation-only checks on the handshake invariants.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         assert (!$isunknown(io_cmd_v_o))
            else $error("bp_io_cmd_arbiter: io_cmd_v_o is X");
         assert (!(io_resp_yumi_o && fifo_empty && !io_resp_v_i))
            else $error("bp_io_cmd_arbiter: pop on empty tag fifo");
         if (orphan_error_en_p && orphan_hit) begin
            $error("bp_io_cmd_arbiter: orphan response with no outstanding command");
         end
      end
   end
`endif

endmodule

// File: tb/tb_bp_io_cmd_arbiter.sv
// Bench for bp_io_cmd_arbiter: a directed vector table, a hand-written backpressure sequence,
// and randomized traffic checked against a queue-based reference model.
module tb_bp_io_cmd_arbiter;

   localparam int unsigned NumReq = 2;
   localparam int unsigned W      = 32;
   localparam int unsigned MaxOut = 8;
   localparam int unsigned CntW   = $clog2(MaxOut + 1);

   logic                   clk_i = 1'b0;
   logic                   reset_i;
   logic [NumReq*W-1:0]    req_cmd_i;
   logic [NumReq-1:0]      req_cmd_v_i;
   logic [NumReq-1:0]      req_cmd_yumi_o;
   logic [NumReq*W-1:0]    req_resp_o;
   logic [NumReq-1:0]      req_resp_v_o;
   logic [NumReq-1:0]      req_resp_ready_and_i;
   logic [W-1:0]           io_cmd_o;
   logic                   io_cmd_v_o;
   logic                   io_cmd_ready_and_i;
   logic [W-1:0]           io_resp_i;
   logic                   io_resp_v_i;
   logic                   io_resp_yumi_o;
   logic [CntW-1:0]        outstanding_o;
   logic                   orphan_resp_o;

   always #5 clk_i = ~clk_i;

   bp_io_cmd_arbiter #(
      .num_req_p        (NumReq),
      .io_msg_width_p   (W),
      .max_outstanding_p(MaxOut),
      .orphan_error_en_p(1'b0)
   ) dut (
      .clk_i               (clk_i),
      .reset_i             (reset_i),
      .req_cmd_i           (req_cmd_i),
      .req_cmd_v_i         (req_cmd_v_i),
      .req_cmd_yumi_o      (req_cmd_yumi_o),
      .req_resp_o          (req_resp_o),
      .req_resp_v_o        (req_resp_v_o),
      .req_resp_ready_and_i(req_resp_ready_and_i),
      .io_cmd_o            (io_cmd_o),
      .io_cmd_v_o          (io_cmd_v_o),
      .io_cmd_ready_and_i  (io_cmd_ready_and_i),
      .io_resp_i           (io_resp_i),
      .io_resp_v_i         (io_resp_v_i),
      .io_resp_yumi_o      (io_resp_yumi_o),
      .outstanding_o       (outstanding_o),
      .orphan_resp_o       (orphan_resp_o)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit       rst;
      bit [1:0] v;
      bit       rdy;
      bit       rv;
      bit [1:0] rr;
      bit       e_cv;
      bit [1:0] e_y;
      bit [1:0] e_rv;
      bit       e_ry;
      int       e_out;
      bit       e_orph;
   } vec_t;

   localparam int NumVec = 27;
   vec_t tbl [NumVec];

   function automatic vec_t mk(bit rst, bit [1:0] v, bit rdy, bit rv, bit [1:0] rr, bit e_cv,
                               bit [1:0] e_y, bit [1:0] e_rv, bit e_ry, int e_out, bit e_orph);
      vec_t t;
      t.rst = rst; t.v = v; t.rdy = rdy; t.rv = rv; t.rr = rr;
      t.e_cv = e_cv; t.e_y = e_y; t.e_rv = e_rv; t.e_ry = e_ry; t.e_out = e_out;
      t.e_orph = e_orph;
      return t;
   endfunction

   task automatic fill_table();
      // Single requester: three grants, then three responses to req0.
      tbl[0] = mk(0, 2'b01, 1, 0, 2'b00, 1, 2'b01, 2'b00, 0, 0, 0);
      tbl[1] = mk(0, 2'b01, 1, 0, 2'b00, 1, 2'b01, 2'b00, 0, 1, 0);
      tbl[2] = mk(0, 2'b01, 1, 0, 2'b00, 1, 2'b01, 2'b00, 0, 2, 0);
      tbl[3] = mk(0, 2'b00, 1, 1, 2'b11, 0, 2'b00, 2'b01, 1, 3, 0);
      tbl[4] = mk(0, 2'b00, 1, 1, 2'b11, 0, 2'b00, 2'b01, 1, 2, 0);
      tbl[5] = mk(0, 2'b00, 1, 1, 2'b11, 0, 2'b00, 2'b01, 1, 1, 0);
      tbl[6] = mk(0, 2'b00, 1, 0, 2'b11, 0, 2'b00, 2'b00, 0, 0, 0);
      // Reset so fairness starts from pointer 0.
      tbl[7] = mk(1, 2'b11, 1, 1, 2'b11, 0, 2'b00, 2'b00, 0, 0, 0);
      // Both requesters valid for 8 cycles, filling the FIFO.
      for (int k = 0; k < 8; k++) begin
`ifdef BP_IO_ARB_FIXED_PRIO_EN
         tbl[8+k] = mk(0, 2'b11, 1, 0, 2'b00, 1, 2'b01, 2'b00, 0, k, 0);
`else
         tbl[8+k] = mk(0, 2'b11, 1, 0, 2'b00, 1, (k % 2 == 0) ? 2'b01 : 2'b10, 2'b00, 0, k, 0);
`endif
      end
      // Full: no grant; a pop does not unblock the same cycle; a grant follows.
      tbl[16] = mk(0, 2'b11, 1, 0, 2'b00, 0, 2'b00, 2'b00, 0, 8, 0);
      tbl[17] = mk(0, 2'b11, 1, 1, 2'b11, 0, 2'b00, 2'b01, 1, 8, 0);
      tbl[18] = mk(0, 2'b11, 1, 0, 2'b00, 1, 2'b01, 2'b00, 0, 7, 0);
      // Reset with a full FIFO: outputs forced low, count cleared on the next cycle.
      tbl[19] = mk(1, 2'b11, 1, 1, 2'b11, 0, 2'b00, 2'b00, 0, 8, 0);
      tbl[20] = mk(0, 2'b00, 1, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0);
      // Orphan response is consumed, dropped and sets the sticky flag.
      tbl[21] = mk(0, 2'b00, 1, 1, 2'b00, 0, 2'b00, 2'b00, 1, 0, 0);
      tbl[22] = mk(0, 2'b00, 1, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 1);
      // The command valid does not wait for ready.
      tbl[23] = mk(0, 2'b01, 0, 0, 2'b00, 1, 2'b00, 2'b00, 0, 0, 1);
      tbl[24] = mk(1, 2'b00, 1, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 1);
      tbl[25] = mk(0, 2'b00, 1, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0);
      // Pointer is back at 0 after reset, so req0 wins.
      tbl[26] = mk(0, 2'b11, 1, 0, 2'b00, 1, 2'b01, 2'b00, 0, 0, 0);
   endtask

   // ---------------- reference model ----------------
   int tagq [$];
   int rr_m;
   bit orphan_m;

   task automatic model_cycle(input string tag);
      int  win, sz, h;
      bit  found, exp_v, exp_ry;
      logic [1:0] exp_y, exp_rv;
      @(negedge clk_i);
      sz    = tagq.size();
      win   = 0;
      found = 0;
      for (int k = 0; k < NumReq; k++) begin
         int idx;
`ifdef BP_IO_ARB_FIXED_PRIO_EN
         idx = k;
`else
         idx = (rr_m + k) % NumReq;
`endif
         if (!found && req_cmd_v_i[idx]) begin
            found = 1;
            win   = idx;
         end
      end
      exp_v  = !reset_i && found && (sz < MaxOut);
      exp_y  = (exp_v && io_cmd_ready_and_i) ? (2'b01 << win) : 2'b00;
      exp_rv = 2'b00;
      exp_ry = 0;
      h      = 0;
      if (!reset_i) begin
         if (sz == 0) begin
            exp_ry = io_resp_v_i;
         end else begin
            h      = tagq[0];
            exp_rv = io_resp_v_i ? (2'b01 << h) : 2'b00;
            exp_ry = io_resp_v_i && req_resp_ready_and_i[h];
         end
      end
      check({tag, " cmd_v"}, 64'(io_cmd_v_o), 64'(exp_v));
      check({tag, " cmd_yumi"}, 64'(req_cmd_yumi_o), 64'(exp_y));
      check({tag, " resp_v"}, 64'(req_resp_v_o), 64'(exp_rv));
      check({tag, " resp_yumi"}, 64'(io_resp_yumi_o), 64'(exp_ry));
      check({tag, " outstanding"}, 64'(outstanding_o), 64'(sz));
      check({tag, " orphan"}, 64'(orphan_resp_o), 64'(orphan_m));
      if (exp_v) check({tag, " cmd_data"}, 64'(io_cmd_o), 64'(req_cmd_i[win*W +: W]));
      if (exp_rv != 2'b00) check({tag, " resp_data"}, 64'(req_resp_o[h*W +: W]), 64'(io_resp_i));
      @(posedge clk_i);
      if (reset_i) begin
         tagq.delete();
         rr_m     = 0;
         orphan_m = 0;
      end else begin
         if (exp_ry && sz > 0) void'(tagq.pop_front());
         if (io_resp_v_i && sz == 0) orphan_m = 1;
         if (exp_v && io_cmd_ready_and_i) begin
            tagq.push_back(win);
            rr_m = (win + 1) % NumReq;
         end
      end
      #1;
   endtask

   task automatic plain_reset();
      reset_i              = 1'b1;
      req_cmd_v_i          = '0;
      io_resp_v_i          = 1'b0;
      io_cmd_ready_and_i   = 1'b0;
      req_resp_ready_and_i = '0;
      repeat (2) @(posedge clk_i);
      #1;
      reset_i = 1'b0;
      tagq.delete();
      rr_m     = 0;
      orphan_m = 0;
   endtask

   initial begin
      req_cmd_i = {32'h2222_0001, 32'h1111_0000};
      io_resp_i = 32'hBEEF_0000;
      fill_table();
      plain_reset();

      // Directed table.
      for (int n = 0; n < NumVec; n++) begin
         int sel;
         reset_i              = tbl[n].rst;
         req_cmd_v_i          = tbl[n].v;
         io_cmd_ready_and_i   = tbl[n].rdy;
         io_resp_v_i          = tbl[n].rv;
         req_resp_ready_and_i = tbl[n].rr;
         io_resp_i            = 32'hBEEF_0000 + 32'(n);
         @(negedge clk_i);
         check($sformatf("vec%0d cmd_v", n), 64'(io_cmd_v_o), 64'(tbl[n].e_cv));
         check($sformatf("vec%0d cmd_yumi", n), 64'(req_cmd_yumi_o), 64'(tbl[n].e_y));
         check($sformatf("vec%0d resp_v", n), 64'(req_resp_v_o), 64'(tbl[n].e_rv));
         check($sformatf("vec%0d resp_yumi", n), 64'(io_resp_yumi_o), 64'(tbl[n].e_ry));
         check($sformatf("vec%0d outstanding", n), 64'(outstanding_o), 64'(tbl[n].e_out));
         check($sformatf("vec%0d orphan", n), 64'(orphan_resp_o), 64'(tbl[n].e_orph));
         if (tbl[n].e_cv) begin
            sel = (tbl[n].e_y == 2'b10) ? 1 : 0;
            check($sformatf("vec%0d cmd_data", n), 64'(io_cmd_o), 64'(req_cmd_i[sel*W +: W]));
         end
         @(posedge clk_i);
         #1;
      end

      // Routing under backpressure: grants 1,0,1, then req1 stalls the head for 5 cycles.
      plain_reset();
      io_cmd_ready_and_i = 1'b1;
      req_cmd_v_i = 2'b10; model_cycle("bp_g1");
      req_cmd_v_i = 2'b01; model_cycle("bp_g0");
      req_cmd_v_i = 2'b10; model_cycle("bp_g1b");
      req_cmd_v_i = 2'b00;
      io_resp_v_i = 1'b1;
      req_resp_ready_and_i = 2'b01;
      for (int k = 0; k < 5; k++) begin
         io_resp_i = 32'hCAFE_0000 + 32'(k);
         model_cycle("bp_stall");
         check("bp_stall no_yumi", 64'(io_resp_yumi_o), 64'd0);
      end
      req_resp_ready_and_i = 2'b11;
      for (int k = 0; k < 3; k++) begin
         io_resp_i = 32'hD00D_0000 + 32'(k);
         model_cycle("bp_drain");
      end
      io_resp_v_i = 1'b0;
      model_cycle("bp_idle");
      check("bp drained", 64'(outstanding_o), 64'd0);

      // Randomized traffic with occasional resets.
      for (int n = 0; n < 1500; n++) begin
         reset_i              = ($urandom_range(0, 59) == 0);
         req_cmd_v_i          = 2'($urandom);
         io_cmd_ready_and_i   = ($urandom_range(0, 3) != 0);
         io_resp_v_i          = ($urandom_range(0, 2) == 0);
         req_resp_ready_and_i = 2'($urandom) | 2'($urandom);
         req_cmd_i            = {$urandom, $urandom};
         io_resp_i            = $urandom;
         model_cycle("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
